// File: rtl/decode_pipe_if.sv
// Decode-stage bus: IF/ID-side inputs, hazard controls, writeback port and
// the registered ID/EX outputs. The master drives the D/W side; the decode
// stage (slave) drives the E side.
interface decode_pipe_if #(
  parameter int unsigned N = 64
);

  // IF/ID side and hazard-unit controls
  logic [31:0]  instr_D;
  logic         valid_D;
  logic         reg2loc_D;
  logic         stall_D;
  logic         flush_D;

  // Writeback port from the WB stage
  logic         regWrite_W;
  logic [4:0]   wa3_W;
  logic [N-1:0] writeData3_W;

  // ID/EX register contents
  logic [N-1:0] readData1_E;
  logic [N-1:0] readData2_E;
  logic [N-1:0] signImm_E;
  logic [4:0]   ra1_E;
  logic [4:0]   ra2_E;
  logic [4:0]   rd_E;
  logic         valid_E;

  modport master (
    output instr_D, valid_D, reg2loc_D, stall_D, flush_D,
    output regWrite_W, wa3_W, writeData3_W,
    input  readData1_E, readData2_E, signImm_E,
    input  ra1_E, ra2_E, rd_E, valid_E
  );

  modport slave (
    input  instr_D, valid_D, reg2loc_D, stall_D, flush_D,
    input  regWrite_W, wa3_W, writeData3_W,
    output readData1_E, readData2_E, signImm_E,
    output ra1_E, ra2_E, rd_E, valid_E
  );

endinterface

// File: rtl/decode_pipe.sv
// LEGv8 decode stage: register file, immediate extension (D/CB/B formats)
// and the ID/EX pipeline register.
// Optional feature: define DECODE_BYPASS_EN to forward a same-cycle
// writeback onto the read ports (XZR is never bypassed).
module decode_pipe #(
  parameter int unsigned N        = 64,
  parameter int unsigned NREGS    = 32,
  parameter int unsigned REG_INIT = 1
) (
  input logic          clk,
  input logic          reset,
  decode_pipe_if.slave bus
);

  // Index width of the storage array; XZR (index NREGS-1) has no storage.
  localparam int unsigned AW      = $clog2(NREGS);
  localparam int unsigned NSTORE  = NREGS - 1;
  localparam logic [4:0]  XZR_IDX = 5'(NREGS - 1);

  localparam int unsigned D_IMM_W  = 9;
  localparam int unsigned CB_IMM_W = 19;
  localparam int unsigned B_IMM_W  = 26;

  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;
  localparam logic [5:0]  OP_B    = 6'b000101;

  logic [N-1:0] rf [NSTORE];

  logic [4:0]   ra1_c;
  logic [4:0]   ra2_c;
  logic [N-1:0] rd1_c;
  logic [N-1:0] rd2_c;
  logic [N-1:0] imm_c;
  logic         wr_en_c;

  logic [N-1:0] rd1_q;
  logic [N-1:0] rd2_q;
  logic [N-1:0] imm_q;
  logic [4:0]   ra1_q;
  logic [4:0]   ra2_q;
  logic [4:0]   rd_q;
  logic         valid_q;

  // Source register addresses; reg2loc picks Rm or Rt for the second port
  always_comb begin
    ra1_c = bus.instr_D[9:5];
    ra2_c = bus.instr_D[20:16];
    if (bus.reg2loc_D) begin
      ra2_c = bus.instr_D[4:0];
    end
  end

  // Writeback is accepted only below XZR; anything else is dropped
  always_comb begin
    wr_en_c = 1'b0;
    if (bus.regWrite_W && (bus.wa3_W < XZR_IDX)) begin
      wr_en_c = 1'b1;
    end
  end

  // Register file storage; writes ignore stall and flush
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(NSTORE); i++) begin
        if (REG_INIT == 1) begin
          rf[i] <= N'(i);
        end else begin
          rf[i] <= '0;
        end
      end
    end else if (wr_en_c) begin
      rf[AW'(bus.wa3_W)] <= bus.writeData3_W;
    end
  end

  // Read port 1: XZR and out-of-range indices read as zero
  always_comb begin
    rd1_c = '0;
    if (ra1_c < XZR_IDX) begin
      rd1_c = rf[AW'(ra1_c)];
`ifdef DECODE_BYPASS_EN
      if (wr_en_c && (bus.wa3_W == ra1_c)) begin
        rd1_c = bus.writeData3_W;
      end
`endif
    end
  end

  // Read port 2: same rules as port 1
  always_comb begin
    rd2_c = '0;
    if (ra2_c < XZR_IDX) begin
      rd2_c = rf[AW'(ra2_c)];
`ifdef DECODE_BYPASS_EN
      if (wr_en_c && (bus.wa3_W == ra2_c)) begin
        rd2_c = bus.writeData3_W;
      end
`endif
    end
  end

  // Immediate extension; first matching format wins, unknown formats give 0
  always_comb begin
    imm_c = '0;
    if ((bus.instr_D[31:21] == OP_LDUR) || (bus.instr_D[31:21] == OP_STUR)) begin
      imm_c = {{(N - D_IMM_W){bus.instr_D[20]}}, bus.instr_D[20:12]};
    end else if (bus.instr_D[31:24] == OP_CBZ) begin
      imm_c = {{(N - CB_IMM_W){bus.instr_D[23]}}, bus.instr_D[23:5]};
    end else if (bus.instr_D[31:26] == OP_B) begin
      imm_c = {{(N - B_IMM_W){bus.instr_D[25]}}, bus.instr_D[25:0]};
    end
  end

  // ID/EX register: reset > flush (bubble) > stall (hold) > load
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd1_q   <= '0;
      rd2_q   <= '0;
      imm_q   <= '0;
      ra1_q   <= '0;
      ra2_q   <= '0;
      rd_q    <= '0;
      valid_q <= 1'b0;
    end else if (bus.flush_D) begin
      rd1_q   <= '0;
      rd2_q   <= '0;
      imm_q   <= '0;
      ra1_q   <= '0;
      ra2_q   <= '0;
      rd_q    <= '0;
      valid_q <= 1'b0;
    end else if (!bus.stall_D) begin
      rd1_q   <= rd1_c;
      rd2_q   <= rd2_c;
      imm_q   <= imm_c;
      ra1_q   <= ra1_c;
      ra2_q   <= ra2_c;
      rd_q    <= bus.instr_D[4:0];
      valid_q <= bus.valid_D;
    end
  end

  // Registered ID/EX contents onto the bus
  assign bus.readData1_E = rd1_q;
  assign bus.readData2_E = rd2_q;
  assign bus.signImm_E   = imm_q;
  assign bus.ra1_E       = ra1_q;
  assign bus.ra2_E       = ra2_q;
  assign bus.rd_E        = rd_q;
  assign bus.valid_E     = valid_q;

endmodule

// File: tb/tb_decode_pipe.sv
// Bench for decode_pipe: a 32-register and a 16-register instance share one
// stimulus stream and are checked against a behavioural model.
module tb_decode_pipe;

  logic        clk;
  logic        reset;
  logic [31:0] instr;
  logic        valid;
  logic        reg2loc;
  logic        stall;
  logic        flush;
  logic        reg_write;
  logic [4:0]  wa3;
  logic [63:0] wd3;

  int checks;
  int errors;

  decode_pipe_if #(.N(64)) bus32 ();
  decode_pipe_if #(.N(64)) bus16 ();

  assign bus32.instr_D      = instr;
  assign bus32.valid_D      = valid;
  assign bus32.reg2loc_D    = reg2loc;
  assign bus32.stall_D      = stall;
  assign bus32.flush_D      = flush;
  assign bus32.regWrite_W   = reg_write;
  assign bus32.wa3_W        = wa3;
  assign bus32.writeData3_W = wd3;

  assign bus16.instr_D      = instr;
  assign bus16.valid_D      = valid;
  assign bus16.reg2loc_D    = reg2loc;
  assign bus16.stall_D      = stall;
  assign bus16.flush_D      = flush;
  assign bus16.regWrite_W   = reg_write;
  assign bus16.wa3_W        = wa3;
  assign bus16.writeData3_W = wd3;

  decode_pipe #(.N(64), .NREGS(32), .REG_INIT(1)) dut32 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus32.slave)
  );

  decode_pipe #(.N(64), .NREGS(16), .REG_INIT(1)) dut16 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus16.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference state: architectural registers and expected ID/EX per instance
  int          nregs [2];
  logic [63:0] mreg  [2][32];
  logic [63:0] e_rd1 [2];
  logic [63:0] e_rd2 [2];
  logic [63:0] e_imm [2];
  logic [4:0]  e_ra1 [2];
  logic [4:0]  e_ra2 [2];
  logic [4:0]  e_rd  [2];
  logic        e_v   [2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Sign-extended immediate computed by plain integer arithmetic
  function automatic logic [63:0] ref_imm(input logic [31:0] i);
    longint v;
    v = 0;
    if (i[31:21] == 11'h7C2 || i[31:21] == 11'h7C0) begin
      v = longint'(64'(i[20:12]));
      if (v >= 256) v = v - 512;
    end else if (i[31:24] == 8'hB4) begin
      v = longint'(64'(i[23:5]));
      if (v >= 262144) v = v - 524288;
    end else if (i[31:26] == 6'h05) begin
      v = longint'(64'(i[25:0]));
      if (v >= 33554432) v = v - 67108864;
    end
    return 64'(v);
  endfunction

  function automatic logic [63:0] ref_read(input int k, input logic [4:0] a);
    if (int'(a) >= nregs[k] - 1) return 64'd0;
`ifdef DECODE_BYPASS_EN
    if (reg_write && wa3 == a) return wd3;
`endif
    return mreg[k][a];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 32; i++) mreg[k][i] = (i < nregs[k] - 1) ? 64'(i) : 64'd0;
      e_rd1[k] = '0; e_rd2[k] = '0; e_imm[k] = '0;
      e_ra1[k] = '0; e_ra2[k] = '0; e_rd[k] = '0; e_v[k] = 1'b0;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, " rd1_32"}, bus32.readData1_E, e_rd1[0]);
    check({tag, " rd2_32"}, bus32.readData2_E, e_rd2[0]);
    check({tag, " imm_32"}, bus32.signImm_E,   e_imm[0]);
    check({tag, " ra1_32"}, 64'(bus32.ra1_E),  64'(e_ra1[0]));
    check({tag, " ra2_32"}, 64'(bus32.ra2_E),  64'(e_ra2[0]));
    check({tag, " rd_32"},  64'(bus32.rd_E),   64'(e_rd[0]));
    check({tag, " v_32"},   64'(bus32.valid_E), 64'(e_v[0]));
    check({tag, " rd1_16"}, bus16.readData1_E, e_rd1[1]);
    check({tag, " rd2_16"}, bus16.readData2_E, e_rd2[1]);
    check({tag, " imm_16"}, bus16.signImm_E,   e_imm[1]);
    check({tag, " ra1_16"}, 64'(bus16.ra1_E),  64'(e_ra1[1]));
    check({tag, " ra2_16"}, 64'(bus16.ra2_E),  64'(e_ra2[1]));
    check({tag, " rd_16"},  64'(bus16.rd_E),   64'(e_rd[1]));
    check({tag, " v_16"},   64'(bus16.valid_E), 64'(e_v[1]));
  endtask

  // Advance one clock: update the model from the current inputs, then compare
  task automatic cycle(input string tag);
    logic [4:0] a1;
    logic [4:0] a2;
    a1 = instr[9:5];
    a2 = reg2loc ? instr[4:0] : instr[20:16];
    for (int k = 0; k < 2; k++) begin
      if (flush) begin
        e_rd1[k] = '0; e_rd2[k] = '0; e_imm[k] = '0;
        e_ra1[k] = '0; e_ra2[k] = '0; e_rd[k] = '0; e_v[k] = 1'b0;
      end else if (!stall) begin
        e_rd1[k] = ref_read(k, a1);
        e_rd2[k] = ref_read(k, a2);
        e_imm[k] = ref_imm(instr);
        e_ra1[k] = a1;
        e_ra2[k] = a2;
        e_rd[k]  = instr[4:0];
        e_v[k]   = valid;
      end
    end
    for (int k = 0; k < 2; k++) begin
      if (reg_write && int'(wa3) < nregs[k] - 1) mreg[k][wa3] = wd3;
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic idle_inputs();
    instr = '0; valid = 0; reg2loc = 0; stall = 0; flush = 0;
    reg_write = 0; wa3 = '0; wd3 = '0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 4))
      0:       return {11'h7C2, r[20:0]};
      1:       return {11'h7C0, r[20:0]};
      2:       return {8'hB4, r[23:0]};
      3:       return {6'h05, r[25:0]};
      default: return r;
    endcase
  endfunction

  initial begin
    checks = 0;
    errors = 0;
    nregs[0] = 32;
    nregs[1] = 16;
    idle_inputs();
    reset = 1'b1;
    model_reset();
    #12;
    check_all("reset");
    reset = 1'b0;

    // LDUR X1,[X31,#8] with reg2loc=1
    instr = 32'hF84083E1; valid = 1; reg2loc = 1;
    cycle("ldur");
    check("ldur rd1", bus32.readData1_E, 64'd0);
    check("ldur rd2", bus32.readData2_E, 64'd1);
    check("ldur imm", bus32.signImm_E, 64'd8);
    check("ldur rd",  64'(bus32.rd_E), 64'd1);
    check("ldur v",   64'(bus32.valid_E), 64'd1);

    // CBZ with imm19 all ones, then B with imm26 = 16
    instr = 32'hB4FFFFE0; reg2loc = 0;
    cycle("cbz");
    check("cbz imm", bus32.signImm_E, 64'hFFFF_FFFF_FFFF_FFFF);
    instr = 32'h14000010;
    cycle("b");
    check("b imm", bus32.signImm_E, 64'd16);

    // Same-cycle write/read of X5
    instr = 32'h000000A0; reg_write = 1; wa3 = 5'd5; wd3 = 64'hABCD;
    cycle("raw");
`ifdef DECODE_BYPASS_EN
    check("raw bypass", bus32.readData1_E, 64'hABCD);
`else
    check("raw old", bus32.readData1_E, 64'd5);
`endif
    reg_write = 0;
    cycle("raw_next");
    check("raw next", bus32.readData1_E, 64'hABCD);

    // Write to XZR is dropped; X20 reads zero on the 16-register instance
    reg_write = 1; wa3 = 5'd31; wd3 = 64'h1234; instr = 32'h000003E0;
    cycle("xzr_wr");
    reg_write = 0;
    cycle("xzr_rd");
    check("xzr rd", bus32.readData1_E, 64'd0);
    instr = 32'h00000280;
    cycle("x20");
    check("x20 n16", bus16.readData1_E, 64'd0);
    check("x20 n32", bus32.readData1_E, 64'd20);

    // Stall holds for three cycles while instr changes, then flush wins
    instr = 32'hF84083E1; valid = 1; reg2loc = 1;
    cycle("pre_stall");
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      instr = rand_instr(); valid = 1'($urandom);
      cycle("stall");
    end
    check("stall imm", bus32.signImm_E, 64'd8);
    flush = 1;
    cycle("flush");
    check("flush v", 64'(bus32.valid_E), 64'd0);
    check("flush rd2", bus32.readData2_E, 64'd0);
    stall = 0; flush = 0;

    // Randomised traffic
    for (int n = 0; n < 300; n++) begin
      instr     = rand_instr();
      valid     = 1'($urandom);
      reg2loc   = 1'($urandom);
      stall     = ($urandom_range(0, 5) == 0);
      flush     = ($urandom_range(0, 9) == 0);
      reg_write = ($urandom_range(0, 2) != 0);
      wa3       = 5'($urandom);
      wd3       = {$urandom, $urandom};
      cycle("rand");
    end

    // Asynchronous reset between edges while valid_E=1
    idle_inputs();
    instr = 32'h00000000; valid = 1;
    cycle("pre_reset");
    check("pre_reset v", 64'(bus32.valid_E), 64'd1);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_all("async_reset");
    #1;
    reset = 1'b0;
    instr = 32'h000000E0; valid = 1;
    cycle("x7");
    check("x7 rd1", bus32.readData1_E, 64'd7);
    check("x7 rd1 n16", bus16.readData1_E, 64'd7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_pipe.md
Name: decode_pipe

Overview:
- Parametrised decode stage for the pipelined LEGv8 core.
- Contains the register file, operand-B source select, immediate extension for D/CB/B formats, and the ID/EX pipeline register.
- Sits between the IF/ID register and the execute stage.
- Writeback arrives from the WB stage on a dedicated write port.
- Stall and flush inputs come from the hazard unit.

Parameters:
- N, 64, data and register width in bits.
- NREGS, 32, register count (8, 16 or 32); index ≥ NREGS-1 is the zero register XZR.
- REG_INIT, 1, reset contents: 1 gives X_i = i, 0 gives all zero.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- instr_D  in  32  instruction from IF/ID.
- valid_D  in  1  instr_D is a real instruction.
- reg2loc_D  in  1  0: ra2 = instr_D[20:16]; 1: ra2 = instr_D[4:0].
- stall_D  in  1  hold the ID/EX register.
- flush_D  in  1  load a bubble into ID/EX.
- regWrite_W  in  1  writeback enable.
- wa3_W  in  5  writeback address.
- writeData3_W  in  N  writeback data.
- readData1_E  out  N  registered operand 1.
- readData2_E  out  N  registered operand 2.
- signImm_E  out  N  registered extended immediate.
- ra1_E  out  5  registered source address 1 (for the forwarding unit).
- ra2_E  out  5  registered source address 2.
- rd_E  out  5  registered instr[4:0].
- valid_E  out  1  ID/EX holds a real instruction.

Behaviour:
- Reset is asynchronous and active-high; clock is clk (rising edge).
- On reset:
  - All _E outputs go to 0.
  - Register i (i < NREGS-1) is set to i when REG_INIT=1, otherwise 0.
- Register file:
  - Two combinational read ports: ra1 = instr_D[9:5], ra2 selected by reg2loc_D.
  - Reads of any index ≥ NREGS-1 return 0.
  - One write port, committed at the rising edge when regWrite_W=1 and wa3_W < NREGS-1.
  - Writes to XZR or to out-of-range indices are dropped silently.
  - Writes happen every cycle, independent of stall_D and flush_D.
- Immediate extension (combinational on instr_D), first match wins:
  - instr[31:21] = 11111000010 (LDUR) or 11111000000 (STUR): sign-extend instr[20:12].
  - instr[31:24] = 10110100 (CBZ): sign-extend instr[23:5].
  - instr[31:26] = 000101 (B): sign-extend instr[25:0].
  - Otherwise: 0.
  - Result is N bits; extension uses the field MSB.
- ID/EX register, updated at the rising edge with priority reset > flush > stall > load:
  - flush_D=1: all _E outputs become 0; valid_E=0.
  - flush_D=0, stall_D=1: all _E outputs hold.
  - Otherwise: capture the read data, immediate, ra1, ra2, instr[4:0] and valid_D.
- Latency: one cycle from instr_D to the _E outputs.
- valid_D=0 captures the datapath values normally, with valid_E=0.
- Reset mid-stall or mid-flush: reset wins immediately, without waiting for a clock edge.

Optional Feature:
- Macro DECODE_BYPASS_EN.
- Defined:
  - Each read port returns writeData3_W when regWrite_W=1, wa3_W equals the read address, and the address < NREGS-1.
  - A value written back in the same cycle is therefore captured into ID/EX.
  - XZR is never bypassed.
- Undefined:
  - Read ports return array contents only.
  - A same-cycle read-after-write captures the old value; the hazard unit must stall one extra cycle.

Test Plan:
- Reset with REG_INIT=1, then instr_D = 0xF84083E1 (LDUR X1,[X31,#8]), reg2loc_D=1, valid_D=1, one edge → readData1_E=0, readData2_E=1, signImm_E=8, rd_E=1, valid_E=1.
- instr_D = CBZ with imm19 = 0x7FFFF → signImm_E = 0xFFFFFFFFFFFFFFFF. B with imm26 = 0x0000010 → signImm_E = 16.
- regWrite_W=1, wa3_W=5, writeData3_W=0xABCD, same cycle ra1=5 → with DECODE_BYPASS_EN, readData1_E=0xABCD. Without it, readData1_E=5, and the next read gives 0xABCD.
- Write 0x1234 to X31, then read X31 → readData1_E=0. With NREGS=16, a read of X20 → 0.
- Load a valid instruction, then stall_D=1 for 3 cycles while instr_D changes → _E outputs unchanged. Then stall_D=1 and flush_D=1 together → all _E outputs 0, valid_E=0.
- Assert reset between clock edges while valid_E=1 → all outputs 0 immediately. After release, X7 reads 7.
